ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
- AHB3-Lite memory responder: the slave end of the bus that the team's AHB interface and driver exercise.
- Decodes address/control phases, stores writes with byte lanes, returns read data, inserts programmable wait states, and issues two-cycle ERROR responses.
- Serves as the DUT behind the verification environment and as a reusable on-chip SRAM slave.

Parameters:
- MEM_DEPTH, 256, number of HDATA_SIZE-wide words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
- Widths HADDR_SIZE/HDATA_SIZE come from the shared AHB defines (32/32).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data, sampled in data phase.
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; informational, not decoded.
- HPROT  in  4  protection; used only with the optional feature.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HRDATA  out  HDATA_SIZE  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE. Memory contents are not reset.
- Asserting reset mid-transfer abandons the transfer; a pending write is not committed.
- Address phase accepted on a rising HCLK edge when HSEL & HREADY & HTRANS[1]. Register HADDR, HWRITE, HSIZE, and an error flag.
- IDLE/BUSY, or HSEL=0, with HREADY=1: no transfer; next cycle is an OKAY zero-wait response.
- Error flag is set for any of:
  - word index HADDR[..2] >= MEM_DEPTH;
  - HSIZE > 2;
  - misaligned address (halfword with HADDR[0]=1, word with HADDR[1:0]!=0).
- FSM states:
  - IDLE: accept address phase.
    - Error flag set -> ERR1.
    - WAIT_STATES > 0 -> WAIT.
    - Otherwise -> DATA, with HREADYOUT=1.
  - WAIT: HREADYOUT=0, counter decrements from WAIT_STATES; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle.
    - A new address phase may be accepted in the same cycle (pipelined); its state is chosen as from IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
    - Errored write: no memory update.
    - Errored read: HRDATA=0.
    - A new address phase presented here is accepted per AHB rules.
- Write commit: at the edge ending DATA, write the HWDATA byte lanes selected by the registered HSIZE/HADDR[1:0]. Little-endian.
- Read data:
  - HRDATA = array[registered word index], combinational from the registered address, valid whenever HREADYOUT=1 in DATA.
  - Lanes outside the selected size are driven with the stored bytes (not masked).
- Write-then-read to the same address back-to-back: the read returns the new data. The write commits on the edge that ends the read's address phase.

Optional Feature:
- AHB_SLV_PROT_CHECK_EN defined: a write with HPROT[1]=0 (user access) sets the error flag and gets the two-cycle ERROR; reads are unaffected.
- Undefined: HPROT is ignored entirely.

Decomposition:
- Package ahb3lite_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
  - hsize constants (BYTE=0, HALF=1, WORD=2);
  - HRESP_OKAY/HRESP_ERROR;
  - FSM enum slv_state_e;
  - function byte_lane_mask(hsize, addr[1:0]) returning a 4-bit strobe.
- Sub-module ahb3lite_sram_array: MEM_DEPTH x HDATA_SIZE memory, synchronous byte-strobed write port, asynchronous read port.

Test Plan:
- Reset asserted mid-WAIT (WAIT_STATES=3) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the pending write to 0x10 is not stored.
- WAIT_STATES=0:
  - NONSEQ word write 0xDEADBEEF @0x04, then read @0x04 back-to-back -> HRDATA=0xDEADBEEF in the read data phase with no stalls.
  - Byte write 0xAA @0x05 over 0x11223344 @0x04, then word read -> 0x1122AA44.
- WAIT_STATES=2: word read @0x08 -> HREADYOUT low exactly 2 cycles, then high with correct data; repeat with HTRANS=SEQ.
- Word write @0x402 (misaligned) and read @ MEM_DEPTH*4:
  - HRESP=1 with HREADYOUT=0 then 1;
  - memory unchanged;
  - HRDATA=0.
- With AHB_SLV_PROT_CHECK_EN: write HPROT=4'b0001 -> ERROR; HPROT=4'b0011 -> OKAY and data stored. Without the macro, both return OKAY.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite definitions for the SRAM slave and its memory array:
//   - bus widths (HADDR_SIZE / HDATA_SIZE)
//   - htrans_e transfer types, HSIZE encodings, HRESP encodings
//   - slv_state_e, the slave data-phase state machine encoding
//   - byte_lane_mask(): HSIZE + HADDR[1:0] -> 4-bit little-endian strobe
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

  localparam int HADDR_SIZE = 32;
  localparam int HDATA_SIZE = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DATA = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_e;

  // Little-endian lane strobe. Misaligned or oversized transfers never reach
  // the write port, so anything that is not a byte or halfword is a full word.
  function automatic logic [3:0] byte_lane_mask(input logic [2:0] hsize,
                                                input logic [1:0] addr);
    logic [3:0] mask;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb3lite_sram_array.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_array
// MEM_DEPTH x HDATA_SIZE storage with one shared word address:
//   clk    in   write clock
//   we     in   write enable (commit on rising clk)
//   strb   in   4-bit byte-lane strobe, bit n writes wdata[8n+7:8n]
//   addr   in   word address (read and write)
//   wdata  in   write data
//   rdata  out  asynchronous read of mem[addr]
// Contents are never reset.
// ---------------------------------------------------------------------------
module ahb3lite_sram_array
  import ahb3lite_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            strb,
  input  logic [AW-1:0]         addr,
  input  logic [HDATA_SIZE-1:0] wdata,
  output logic [HDATA_SIZE-1:0] rdata
);

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
// AHB3-Lite SRAM responder with byte-lane writes, WAIT_STATES stall cycles in
// every OKAY data phase and a two-cycle ERROR response for bad transfers
// (out-of-range word, HSIZE > word, misaligned address).
//
// Ports:
//   HCLK, HRESETn (async, active-low)
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY  address phase
//   HWDATA                                                    write data phase
//   HRDATA, HREADYOUT, HRESP                                  slave response
//
// Optional build macro AHB_SLV_PROT_CHECK_EN: writes with HPROT[1]=0 (user
// access) are rejected with ERROR. Without it HPROT is ignored. HBURST is
// never decoded.
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [HADDR_SIZE-3:0] DEPTH_WORDS = (HADDR_SIZE-2)'(MEM_DEPTH);

  slv_state_e            state;
  logic [AW-1:0]         idx_q;
  logic [1:0]            lane_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [3:0]            wait_cnt;

  logic                  accept;
  logic                  range_err;
  logic                  size_err;
  logic                  align_err;
  logic                  prot_err;
  logic                  xfer_err;
  logic                  mem_we;
  logic [3:0]            mem_strb;
  logic [HDATA_SIZE-1:0] mem_rdata;
  logic                  unused_ok;

  assign accept = HSEL & HREADY &
                  ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  assign range_err = (HADDR[HADDR_SIZE-1:2] >= DEPTH_WORDS);
  assign size_err  = (HSIZE > HSIZE_WORD);
  assign align_err = ((HSIZE == HSIZE_HALF) & HADDR[0]) |
                     ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

`ifdef AHB_SLV_PROT_CHECK_EN
  assign prot_err  = HWRITE & ~HPROT[1];
  assign unused_ok = ^{HBURST, HPROT[3:2], HPROT[0]};
`else
  assign prot_err  = 1'b0;
  assign unused_ok = ^{HBURST, HPROT};
`endif

  assign xfer_err = range_err | size_err | align_err | prot_err;

  // WAIT and ERR1 hold HREADYOUT low, so a new address phase can only land in
  // IDLE, DATA or ERR2; all three share the accept path in the default arm.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= SLV_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      idx_q     <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        SLV_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state     <= SLV_DATA;
            HREADYOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        SLV_ERR1: begin
          state     <= SLV_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          if (accept) begin
            idx_q   <= HADDR[AW+1:2];
            lane_q  <= HADDR[1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (xfer_err) begin
              state     <= SLV_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state     <= SLV_WAIT;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_OKAY;
              wait_cnt  <= WAIT_INIT;
            end else begin
              state     <= SLV_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= HRESP_OKAY;
            end
          end else begin
            state     <= SLV_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Commit happens on the edge that ends DATA, which is also the edge that
  // accepts a following read, so a back-to-back read sees the new word.
  assign mem_we   = (state == SLV_DATA) & write_q;
  assign mem_strb = byte_lane_mask(size_q, lane_q);

  ahb3lite_sram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_array (
    .clk   (HCLK),
    .we    (mem_we),
    .strb  (mem_strb),
    .addr  (idx_q),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  // Whole stored word is returned regardless of HSIZE; zero outside DATA so
  // errored reads and reset both present 0.
  assign HRDATA = (state == SLV_DATA) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
// Three slaves on one AHB3-Lite bus (WAIT_STATES 0, 2, 3), selected per
// transfer. Directed vectors are run as a pipelined transfer stream; each
// data phase is checked for HRESP, stall count and (for reads) HRDATA.
// A hand-written sequence covers reset asserted in the middle of a WAIT.
// Honours AHB_SLV_PROT_CHECK_EN for the HPROT vectors.
// ---------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

`ifdef AHB_SLV_PROT_CHECK_EN
  localparam logic        PROT_RESP   = 1'b1;
  localparam int          PROT_STALLS = 1;
  localparam logic [31:0] PROT_READ   = 32'h0A0A0A0A;
`else
  localparam logic        PROT_RESP   = 1'b0;
  localparam int          PROT_STALLS = 0;
  localparam logic [31:0] PROT_READ   = 32'h55555555;
`endif

  localparam int NVEC   = 35;
  localparam int BUDGET = 400;

  typedef struct {
    logic [1:0]  tgt;
    logic        sel;
    logic        write;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    int          exp_stalls;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [NVEC];
  int   nvec = 0;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel_bus;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [1:0]  atgt;
  logic [1:0]  dtgt;

  logic [2:0]        hsel_s;
  logic [2:0]        hreadyout_s;
  logic [2:0]        hresp_s;
  logic [2:0][31:0]  hrdata_s;
  logic              hready_bus;
  logic              hresp_bus;
  logic [31:0]       hrdata_bus;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  assign hready_bus = hreadyout_s[dtgt];
  assign hresp_bus  = hresp_s[dtgt];
  assign hrdata_bus = hrdata_s[dtgt];

  for (genvar g = 0; g < 3; g++) begin : g_slv
    assign hsel_s[g] = hsel_bus & (atgt == 2'(g));

    ahb3lite_sram_slave #(
      .MEM_DEPTH   (256),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (hsel_s[g]),
      .HADDR     (haddr),
      .HWDATA    (hwdata),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (hburst),
      .HPROT     (hprot),
      .HTRANS    (htrans),
      .HREADY    (hready_bus),
      .HRDATA    (hrdata_s[g]),
      .HREADYOUT (hreadyout_s[g]),
      .HRESP     (hresp_s[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [1:0] tgt, input logic sel, input logic write,
                        input logic [1:0] trans, input logic [2:0] size,
                        input logic [3:0] prot, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic resp,
                        input int stalls, input logic chk,
                        input logic [31:0] rdata);
    vecs[nvec].tgt        = tgt;
    vecs[nvec].sel        = sel;
    vecs[nvec].write      = write;
    vecs[nvec].trans      = trans;
    vecs[nvec].size       = size;
    vecs[nvec].prot       = prot;
    vecs[nvec].addr       = addr;
    vecs[nvec].wdata      = wdata;
    vecs[nvec].exp_resp   = resp;
    vecs[nvec].exp_stalls = stalls;
    vecs[nvec].chk_rdata  = chk;
    vecs[nvec].exp_rdata  = rdata;
    nvec++;
  endtask

  task automatic wr(input logic [1:0] tgt, input logic [2:0] size,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] prot, input logic resp, input int stalls);
    addVec(tgt, 1'b1, 1'b1, HTRANS_NONSEQ, size, prot, addr, data, resp, stalls,
           1'b0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] tgt, input logic [2:0] size,
                    input logic [31:0] addr, input logic [1:0] trans,
                    input logic resp, input int stalls, input logic [31:0] data);
    addVec(tgt, 1'b1, 1'b0, trans, size, 4'b0011, addr, 32'h0, resp, stalls,
           1'b1, data);
  endtask

  task automatic buildVectors();
    // WAIT_STATES = 0 slave (indices 0..27)
    wr(0, HSIZE_WORD, 32'h000, 32'h0BADF00D, 4'b0011, 1'b0, 0);
    wr(0, HSIZE_WORD, 32'h00C, 32'h600DC0DE, 4'b0011, 1'b0, 0);
    wr(0, HSIZE_WORD, 32'h004, 32'hDEADBEEF, 4'b0011, 1'b0, 0);
    rd(0, HSIZE_WORD, 32'h004, HTRANS_NONSEQ, 1'b0, 0, 32'hDEADBEEF);
    wr(0, HSIZE_WORD, 32'h004, 32'h11223344, 4'b0011, 1'b0, 0);
    wr(0, HSIZE_BYTE, 32'h005, 32'h5566AA77, 4'b0011, 1'b0, 0);
    rd(0, HSIZE_WORD, 32'h004, HTRANS_NONSEQ, 1'b0, 0, 32'h1122AA44);
    wr(0, HSIZE_WORD, 32'h008, 32'hCAFEF00D, 4'b0011, 1'b0, 0);
    wr(0, HSIZE_HALF, 32'h00A, 32'h12345678, 4'b0011, 1'b0, 0);
    rd(0, HSIZE_BYTE, 32'h00B, HTRANS_NONSEQ, 1'b0, 0, 32'h1234F00D);
    addVec(0, 1'b1, 1'b0, HTRANS_IDLE, HSIZE_WORD, 4'b0011, 32'h0, 32'h0,
           1'b0, 0, 1'b0, 32'h0);
    wr(0, HSIZE_WORD, 32'h402, 32'h99999999, 4'b0011, 1'b1, 1);
    wr(0, HSIZE_WORD, 32'h00E, 32'hFFFFFFFF, 4'b0011, 1'b1, 1);
    wr(0, HSIZE_HALF, 32'h007, 32'hFFFFFFFF, 4'b0011, 1'b1, 1);
    wr(0, 3'd3,       32'h000, 32'hFFFFFFFF, 4'b0011, 1'b1, 1);
    rd(0, HSIZE_WORD, 32'h400, HTRANS_NONSEQ, 1'b1, 1, 32'h00000000);
    rd(0, HSIZE_WORD, 32'h000, HTRANS_NONSEQ, 1'b0, 0, 32'h0BADF00D);
    rd(0, HSIZE_WORD, 32'h00C, HTRANS_NONSEQ, 1'b0, 0, 32'h600DC0DE);
    rd(0, HSIZE_WORD, 32'h004, HTRANS_NONSEQ, 1'b0, 0, 32'h1122AA44);
    wr(0, HSIZE_WORD, 32'h010, 32'h0A0A0A0A, 4'b0011, 1'b0, 0);
    wr(0, HSIZE_WORD, 32'h010, 32'h55555555, 4'b0001, PROT_RESP, PROT_STALLS);
    wr(0, HSIZE_WORD, 32'h014, 32'h77777777, 4'b0011, 1'b0, 0);
    rd(0, HSIZE_WORD, 32'h010, HTRANS_NONSEQ, 1'b0, 0, PROT_READ);
    rd(0, HSIZE_WORD, 32'h014, HTRANS_NONSEQ, 1'b0, 0, 32'h77777777);
    wr(0, HSIZE_WORD, 32'h3FC, 32'h89ABCDEF, 4'b0011, 1'b0, 0);
    rd(0, HSIZE_WORD, 32'h3FC, HTRANS_NONSEQ, 1'b0, 0, 32'h89ABCDEF);
    addVec(0, 1'b0, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 4'b0011, 32'h004,
           32'hFFFFFFFF, 1'b0, 0, 1'b0, 32'h0);
    rd(0, HSIZE_WORD, 32'h004, HTRANS_NONSEQ, 1'b0, 0, 32'h1122AA44);
    // WAIT_STATES = 2 slave (indices 28..32)
    wr(1, HSIZE_WORD, 32'h008, 32'h13579BDF, 4'b0011, 1'b0, 2);
    rd(1, HSIZE_WORD, 32'h008, HTRANS_NONSEQ, 1'b0, 2, 32'h13579BDF);
    addVec(1, 1'b1, 1'b0, HTRANS_BUSY, HSIZE_WORD, 4'b0011, 32'h00C, 32'h0,
           1'b0, 0, 1'b0, 32'h0);
    rd(1, HSIZE_WORD, 32'h008, HTRANS_SEQ, 1'b0, 2, 32'h13579BDF);
    rd(1, HSIZE_WORD, 32'h404, HTRANS_NONSEQ, 1'b1, 1, 32'h00000000);
    // WAIT_STATES = 3 slave (indices 33..34)
    wr(2, HSIZE_WORD, 32'h010, 32'h01010101, 4'b0011, 1'b0, 3);
    rd(2, HSIZE_WORD, 32'h010, HTRANS_NONSEQ, 1'b0, 3, 32'h01010101);
  endtask

  task automatic driveIdle();
    hsel_bus = 1'b0;
    haddr    = 32'h0;
    hwrite   = 1'b0;
    hsize    = HSIZE_WORD;
    hburst   = 3'd0;
    hprot    = 4'b0011;
    htrans   = HTRANS_IDLE;
  endtask

  task automatic applyStimulus(input int i);
    atgt     = vecs[i].tgt;
    hsel_bus = vecs[i].sel;
    haddr    = vecs[i].addr;
    hwrite   = vecs[i].write;
    hsize    = vecs[i].size;
    hprot    = vecs[i].prot;
    htrans   = vecs[i].trans;
    hburst   = (vecs[i].trans == HTRANS_SEQ) ? 3'd1 : 3'd0;
  endtask

  // Pipelined stream: entered and left just after a rising edge. Responses are
  // sampled on the falling edge; address/data signals change after the rising
  // edge that completed the previous beat.
  task automatic runSeq(input int first, input int last);
    int   ap;
    int   dp;
    int   stalls;
    int   cycles;
    logic rdy;
    ap     = first;
    dp     = -1;
    stalls = 0;
    cycles = 0;
    applyStimulus(ap);
    while ((ap <= last || dp >= 0) && cycles < BUDGET) begin
      @(negedge HCLK);
      cycles++;
      rdy = hready_bus;
      if (dp >= 0) begin
        if (!rdy) begin
          stalls++;
          checkOutput($sformatf("v%0d stall hresp", dp), 32'(hresp_bus),
                      32'(vecs[dp].exp_resp));
        end else begin
          checkOutput($sformatf("v%0d hresp", dp), 32'(hresp_bus),
                      32'(vecs[dp].exp_resp));
          checkOutput($sformatf("v%0d stall count", dp), 32'(stalls),
                      32'(vecs[dp].exp_stalls));
          if (vecs[dp].chk_rdata)
            checkOutput($sformatf("v%0d hrdata", dp), hrdata_bus,
                        vecs[dp].exp_rdata);
        end
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        stalls = 0;
        if (ap <= last) begin
          dp     = ap;
          dtgt   = vecs[ap].tgt;
          hwdata = vecs[ap].wdata;
          ap++;
        end else begin
          dp = -1;
        end
        if (ap <= last) applyStimulus(ap);
        else driveIdle();
      end
    end
    if (cycles >= BUDGET)
      checkOutput($sformatf("seq %0d-%0d cycle budget", first, last),
                  32'(cycles), 32'(BUDGET - 1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESETn = 1'b0;
    atgt    = 2'd0;
    dtgt    = 2'd0;
    hwdata  = 32'h0;
    driveIdle();
    buildVectors();

    repeat (2) @(negedge HCLK);
    checkOutput("reset hreadyout", 32'(hreadyout_s[0]), 32'h1);
    checkOutput("reset hresp",     32'(hresp_s[0]),     32'h0);
    checkOutput("reset hrdata",    hrdata_s[0],         32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    runSeq(0, 27);
    runSeq(28, 32);
    runSeq(33, 33);

    // Write to 0x10 on the 3-wait slave, then reset it two cycles into WAIT.
    atgt     = 2'd2;
    dtgt     = 2'd2;
    hsel_bus = 1'b1;
    haddr    = 32'h010;
    hwrite   = 1'b1;
    hsize    = HSIZE_WORD;
    hprot    = 4'b0011;
    hburst   = 3'd0;
    htrans   = HTRANS_NONSEQ;
    @(negedge HCLK);
    checkOutput("rst addr phase ready", 32'(hready_bus), 32'h1);
    @(posedge HCLK);
    #1;
    hwdata = 32'hFFFF0000;
    driveIdle();
    @(negedge HCLK);
    checkOutput("rst in wait hreadyout", 32'(hreadyout_s[2]), 32'h0);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    checkOutput("rst mid-wait hreadyout", 32'(hreadyout_s[2]), 32'h1);
    checkOutput("rst mid-wait hresp",     32'(hresp_s[2]),     32'h0);
    checkOutput("rst mid-wait hrdata",    hrdata_s[2],         32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    runSeq(34, 34);

    repeat (2) @(posedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
